axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- Single-beat AXI4 slave backed by a 64-bit-wide on-chip memory array.
- Sits directly downstream of the CPU AXI arbiter and services its fetch (id 0) and load/store (id 1) transactions.
- Read and write channels run as independent state machines with programmable response latency, so the arbiter's handshakes are exercised under realistic delays.

Parameters:
- DEPTH_LOG2, 12, log2 of number of 64-bit words (default 32 KiB)
- BASE_ADDR, 32'h8000_0000, byte address of word 0
- RD_LAT, 2, extra cycles between AR handshake and rvalid (0..15)
- WR_LAT, 1, extra cycles between last of AW/W handshake and bvalid (0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- arid  in  4  read id
- araddr  in  32  read byte address
- arlen  in  8  burst length-1, only 0 supported
- arsize  in  3  only 3'b011 supported
- arburst  in  2  ignored
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- rid  out  4  read response id
- rdata  out  64  read data
- rresp  out  2  read response
- rlast  out  1  last beat
- rvalid  out  1  R valid
- rready  in  1  R ready
- awid  in  4  write id
- awaddr  in  32  write byte address
- awlen  in  8  only 0 supported
- awsize  in  3  only 3'b011 supported
- awburst  in  2  ignored
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wdata  in  64  write data
- wstrb  in  8  byte enables
- wlast  in  1  ignored
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  4  write response id
- bresp  out  2  write response
- bvalid  out  1  B valid
- bready  in  1  B ready

Behaviour:
- Reset:
  - All outputs are registered and reset to 0; FSMs go to IDLE; counters clear.
  - Memory contents are NOT cleared.
  - Reset mid-transaction aborts it: a pending write not yet committed is dropped.
  - arready, awready and wready rise the first cycle after reset deasserts.
- Address decode:
  - in_range = araddr >= BASE_ADDR && araddr < BASE_ADDR + 2^(DEPTH_LOG2+3).
  - index = (addr - BASE_ADDR) >> 3, truncated to DEPTH_LOG2 bits; addr[2:0] is ignored (8-byte aligned access).
- Response codes (same rules for writes):
  - OKAY 2'b00.
  - SLVERR 2'b10 if len != 0 or size != 3'b011; still a single beat, no memory access.
  - DECERR 2'b11 if out of range; rdata = 0, no memory access.
  - Out-of-range takes precedence over SLVERR.
- Read FSM (R_IDLE, R_LAT, R_RESP):
  - R_IDLE: arready = 1. On arvalid && arready, latch arid/araddr/len/size, drop arready, load cnt = RD_LAT, go R_LAT.
  - R_LAT: if cnt == 0, read mem[index] into rdata, set rvalid = 1, rlast = 1, rid, rresp, go R_RESP; else decrement cnt.
  - R_RESP: hold rid/rdata/rresp/rlast/rvalid stable until rready. On rvalid && rready, clear rvalid/rlast, go R_IDLE; arready = 1 the next cycle.
  - Timing: AR handshake at edge T gives rvalid high from edge T+1+RD_LAT; one outstanding read max.
- Write FSM (W_IDLE, W_LAT, W_RESP):
  - W_IDLE: awready = wready = 1 independently. AW and W may handshake in either order or the same cycle; each channel latches its payload and drops its ready on handshake.
  - When both are latched, load cnt = WR_LAT, go W_LAT.
  - W_LAT: if cnt == 0, commit the write, set bvalid = 1 with bid = latched awid and bresp, go W_RESP; else decrement cnt.
  - Commit (OKAY only): for i in 0..7, byte i of mem[index] = wdata byte i iff wstrb[i]. wstrb == 0 commits nothing and responds OKAY.
  - W_RESP: hold bvalid/bid/bresp until bready. On handshake, go W_IDLE; awready = wready = 1 the next cycle.
- Simultaneous read sample and write commit to the same index in one cycle: read returns pre-write data.
- Read and write paths never stall each other.

Test Plan:
- Reset, then write 0x1122334455667788 to 0x80000008 with wstrb 0xFF, AW and W in the same cycle -> bvalid 2 cycles after handshake, bid 1, bresp 0; read 0x80000008 (arid 0, RD_LAT 2) -> rvalid 3 cycles after AR handshake, rdata 0x1122334455667788, rid 0, rresp 0, rlast 1.
- W arrives 3 cycles before AW, wstrb 0x0F, wdata 0xAAAAAAAA_BBBBBBBB over the prior word -> read returns 0x11223344_BBBBBBBB.
- Hold rready low 5 cycles after rvalid -> rvalid/rdata/rid stable throughout, arready stays 0; after rready, arready = 1 next cycle.
- Read 0x7FFFFFF8 and 0x80008000 -> rresp 2'b11, rdata 0; arlen = 3 at 0x80000000 -> rresp 2'b10, single beat with rlast = 1.
- Read commit and write commit to 0x80000010 in the same cycle, old 0x0, new 0x5 -> read returns 0x0; next read returns 0x5.
- Assert reset while in R_LAT and W_LAT -> rvalid/bvalid stay 0, pending write not committed, readies = 1 the cycle after reset deasserts, earlier memory contents retained.

Source files
------------

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : Single-beat AXI4 slave in front of a 64-bit-wide on-chip
//               memory. The read and write channels are independent state
//               machines. Each one adds a programmable response latency.
//
//               Ports
//                 clk, reset                  clock, sync active-high reset
//                 ar* / arready               read address channel
//                 r*  / rready                read data channel
//                 aw* / awready               write address channel
//                 w*  / wready                write data channel
//                 b*  / bready                write response channel
// Revision    : 1.0  initial release
// ============================================================================
module axi_sram_slave #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [63:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          c_DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [32:0] c_END    = {1'b0, BASE_ADDR} + (33'd1 << (DEPTH_LOG2 + 3));
    localparam logic [3:0]  c_RD_LAT = 4'(RD_LAT);
    localparam logic [3:0]  c_WR_LAT = 4'(WR_LAT);

    localparam logic [1:0]  c_OKAY   = 2'b00;
    localparam logic [1:0]  c_SLVERR = 2'b10;
    localparam logic [1:0]  c_DECERR = 2'b11;

    localparam logic [1:0]  c_R_IDLE = 2'd0;
    localparam logic [1:0]  c_R_LAT  = 2'd1;
    localparam logic [1:0]  c_R_RESP = 2'd2;

    localparam logic [1:0]  c_W_IDLE = 2'd0;
    localparam logic [1:0]  c_W_LAT  = 2'd1;
    localparam logic [1:0]  c_W_RESP = 2'd2;

    // Response code for a request. Out-of-range is checked first so that it
    // wins over an unsupported length/size.
    function automatic logic [1:0] f_resp(input logic [31:0] addr,
                                          input logic [7:0]  len,
                                          input logic [2:0]  size);
        logic [32:0] a;
        a = {1'b0, addr};
        if (a < {1'b0, BASE_ADDR} || a >= c_END)
            return c_DECERR;
        if (len != 8'd0 || size != 3'b011)
            return c_SLVERR;
        return c_OKAY;
    endfunction

    logic [63:0] r_mem [c_DEPTH];

    // ------------------------------------------------------------------
    // Address decode on the incoming request (latched at handshake)
    // ------------------------------------------------------------------
    logic [31:0] w_ar_off;
    logic [31:0] w_aw_off;
    assign w_ar_off = araddr - BASE_ADDR;
    assign w_aw_off = awaddr - BASE_ADDR;

    // Unused bits: burst type, wlast and the offset bits outside the index.
    logic w_unused;
    assign w_unused = &{1'b0, arburst, awburst, wlast, w_ar_off, w_aw_off};

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic [1:0]            r_rd_state;
    logic [1:0]            w_rd_state_nxt;
    logic [3:0]            r_rd_cnt;
    logic [3:0]            r_ar_id;
    logic [1:0]            r_ar_resp;
    logic [DEPTH_LOG2-1:0] r_ar_idx;
    logic                  w_ar_hs;
    logic                  w_r_hs;

    assign w_ar_hs = arvalid & arready;
    assign w_r_hs  = rvalid & rready;

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (w_ar_hs)             w_rd_state_nxt = c_R_LAT;
            c_R_LAT:  if (r_rd_cnt == 4'd0)    w_rd_state_nxt = c_R_RESP;
            c_R_RESP: if (w_r_hs)              w_rd_state_nxt = c_R_IDLE;
            default:                           w_rd_state_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_state <= c_R_IDLE;
            r_rd_cnt   <= 4'd0;
            r_ar_id    <= 4'd0;
            r_ar_resp  <= c_OKAY;
            r_ar_idx   <= '0;
            arready    <= 1'b0;
            rid        <= 4'd0;
            rdata      <= 64'd0;
            rresp      <= 2'b00;
            rlast      <= 1'b0;
            rvalid     <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            case (r_rd_state)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_id   <= arid;
                        r_ar_resp <= f_resp(araddr, arlen, arsize);
                        r_ar_idx  <= w_ar_off[DEPTH_LOG2+2:3];
                        r_rd_cnt  <= c_RD_LAT;
                        arready   <= 1'b0;
                    end else begin
                        arready   <= 1'b1;
                    end
                end
                c_R_LAT: begin
                    if (r_rd_cnt == 4'd0) begin
                        // Non-blocking sample: a write committing on this
                        // same edge is not visible yet (old data returned).
                        rdata  <= (r_ar_resp == c_OKAY) ? r_mem[r_ar_idx] : 64'd0;
                        rid    <= r_ar_id;
                        rresp  <= r_ar_resp;
                        rlast  <= 1'b1;
                        rvalid <= 1'b1;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 4'd1;
                    end
                end
                c_R_RESP: begin
                    if (w_r_hs) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [1:0]            r_wr_state;
    logic [1:0]            w_wr_state_nxt;
    logic [3:0]            r_wr_cnt;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [3:0]            r_aw_id;
    logic [1:0]            r_aw_resp;
    logic [DEPTH_LOG2-1:0] r_aw_idx;
    logic [63:0]           r_w_data;
    logic [7:0]            r_w_strb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_aw_have;
    logic                  w_w_have;
    logic                  w_wr_commit;

    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    assign w_b_hs    = bvalid & bready;
    // "have" includes a handshake on this very edge, so AW and W arriving
    // together (or the second of the two) move straight to the latency stage.
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got | w_w_hs;

    assign w_wr_commit = !reset && (r_wr_state == c_W_LAT) && (r_wr_cnt == 4'd0)
                         && (r_aw_resp == c_OKAY);

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            c_W_IDLE: if (w_aw_have && w_w_have) w_wr_state_nxt = c_W_LAT;
            c_W_LAT:  if (r_wr_cnt == 4'd0)      w_wr_state_nxt = c_W_RESP;
            c_W_RESP: if (w_b_hs)                w_wr_state_nxt = c_W_IDLE;
            default:                             w_wr_state_nxt = c_W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= c_W_IDLE;
            r_wr_cnt   <= 4'd0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_aw_id    <= 4'd0;
            r_aw_resp  <= c_OKAY;
            r_aw_idx   <= '0;
            r_w_data   <= 64'd0;
            r_w_strb   <= 8'd0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bid        <= 4'd0;
            bresp      <= 2'b00;
            bvalid     <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            case (r_wr_state)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_id   <= awid;
                        r_aw_resp <= f_resp(awaddr, awlen, awsize);
                        r_aw_idx  <= w_aw_off[DEPTH_LOG2+2:3];
                        r_aw_got  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_data <= wdata;
                        r_w_strb <= wstrb;
                        r_w_got  <= 1'b1;
                    end
                    if (w_aw_have && w_w_have) begin
                        r_aw_got <= 1'b0;
                        r_w_got  <= 1'b0;
                        r_wr_cnt <= c_WR_LAT;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                    end else begin
                        awready  <= !w_aw_have;
                        wready   <= !w_w_have;
                    end
                end
                c_W_LAT: begin
                    if (r_wr_cnt == 4'd0) begin
                        bid    <= r_aw_id;
                        bresp  <= r_aw_resp;
                        bvalid <= 1'b1;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 4'd1;
                    end
                end
                c_W_RESP: begin
                    if (w_b_hs) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_w_strb[i])
                    r_mem[r_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
